// File: rtl/shifter_pkg.sv
// Shared types and the one-bit step helper for the multi-cycle left shifter.
// The rotate variant is selected in shl_step by LEFT_SHIFTER_SEQ_ROTATE_EN.
package shifter_pkg;

    localparam int SHL_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } shl_state_t;

    // Bit entering the LSB on one step: the old MSB when rotating, zero when shifting.
    function automatic logic shl_fill_bit(input logic msb, input logic rotate);
        return rotate ? msb : 1'b0;
    endfunction

endpackage

// File: rtl/shl_step.sv
// Combinational one-bit left step: next word plus the bit leaving the MSB.
// Build macro LEFT_SHIFTER_SEQ_ROTATE_EN turns the zero-filling shift into a rotate.
module shl_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = SHL_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry
);

`ifdef LEFT_SHIFTER_SEQ_ROTATE_EN
    localparam logic ROTATE = 1'b1;
`else
    localparam logic ROTATE = 1'b0;
`endif

    assign o_carry = i_data[WIDTH-1];
    assign o_data  = {i_data[WIDTH-2:0], shl_fill_bit(i_data[WIDTH-1], ROTATE)};

endmodule

// File: rtl/left_shifter_seq.sv
// Multi-cycle left shifter: one bit per clock, valid/ready on both sides, one operation in flight.
// LEFT_SHIFTER_SEQ_ROTATE_EN (via shl_step) selects rotate-left; ports and timing are unchanged.
module left_shifter_seq
    import shifter_pkg::*;
#(
    parameter int WIDTH   = SHL_DEFAULT_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry,
    output logic               busy
);

    localparam logic [SHAMT_W-1:0] COUNT_ONE = SHAMT_W'(1);

    shl_state_t         r_state;
    shl_state_t         w_state_next;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_step_data;
    logic [SHAMT_W-1:0] r_count;
    logic               r_carry;
    logic               w_step_carry;
    logic               w_accept;

    shl_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_data  (r_data),
        .o_data  (w_step_data),
        .o_carry (w_step_carry)
    );

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign out_data  = r_data;
    assign out_carry = r_carry;

    // NOTE: registered state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = (in_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (r_count == COUNT_ONE) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // The result registers double as the output holding registers while DONE waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_count <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_data  <= in_data;
            r_count <= in_shamt;
            r_carry <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_data  <= w_step_data;
            r_carry <= w_step_carry;
            r_count <= r_count - COUNT_ONE;
        end
    end

endmodule

// File: tb/tb_left_shifter_seq.sv
// Self-checking bench for left_shifter_seq: directed cases plus a random stream
// compared every cycle against a timestamp/arithmetic reference model.
module tb_left_shifter_seq;

    localparam int W      = 8;
    localparam int SW     = 3;
    localparam int N_RAND = 200;
`ifdef LEFT_SHIFTER_SEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_shamt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_carry;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    left_shifter_seq #(
        .WIDTH   (W),
        .SHAMT_W (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result: {carry, data} from plain integer arithmetic.
    function automatic logic [W:0] ref_op(input logic [W-1:0] d, input int s);
        int v;
        int r;
        int c;
        logic [31:0] rv;
        v = int'(d);
        r = v << s;
        if (ROT) r = r | (v >> (W - s));
        rv = 32'(r & ((1 << W) - 1));
        c = (s == 0) ? 0 : ((v >> (W - s)) & 1);
        return {c[0], rv[W-1:0]};
    endfunction

    // Model: an accepted op becomes visible s edges after its accept edge and
    // stays until an edge where it was visible and out_ready was high.
    logic         m_busy = 1'b0;
    int           m_cyc = 0;
    int           m_done = 0;
    logic [W-1:0] m_res = '0;
    logic         m_carry = 1'b0;
    int           m_accepts = 0;
    int           m_completed = 0;
    logic         m_ov;

    assign m_ov = m_busy && (m_cyc >= m_done);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cyc  <= 0;
            m_done <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (!m_busy && in_valid) begin
                {m_carry, m_res} <= ref_op(in_data, int'(in_shamt));
                m_busy           <= 1'b1;
                m_done           <= m_cyc + 1 + int'(in_shamt);
                m_accepts        <= m_accepts + 1;
            end else if (m_ov && out_ready) begin
                m_busy      <= 1'b0;
                m_completed <= m_completed + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_out_carry", out_carry, 0);
            check("rst_busy", busy, 0);
        end else begin
            check("in_ready", in_ready, !m_busy);
            check("busy", busy, m_busy);
            check("out_valid", out_valid, m_ov);
            check("ready_valid_excl", out_valid & in_ready, 0);
            if (m_ov) begin
                check("out_data", out_data, m_res);
                check("out_carry", out_carry, m_carry);
            end
        end
    end

    logic rand_rdy = 1'b0;

    task automatic tick();
        @(negedge clk);
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic directed(input string name, input logic [W-1:0] d, input logic [SW-1:0] s,
                            input logic [W-1:0] exp_d, input logic exp_c);
        int lat;
        @(negedge clk);
        check({name, "_idle_ready"}, in_ready, 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = s;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, int'(s) + 1);
        check({name, "_data"}, out_data, exp_d);
        check({name, "_carry"}, out_carry, exp_c);
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] held_d;
        logic         held_c;
        int           t;
        int           start;
        int           acc_base;
        int           cmp_base;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Hand-computed pins on the reference model itself.
        check("model_b5_3", ref_op(8'hB5, 3), {1'b1, (ROT ? 8'hAD : 8'hA8)});
        check("model_01_7", ref_op(8'h01, 7), {1'b0, 8'h80});
        check("model_81_0", ref_op(8'h81, 0), {1'b0, 8'h81});

        // Reset asserted mid-shift discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_shamt = 3'd5;
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_busy_before_rst", busy, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t1_rst_in_ready", in_ready, 1);
            check("t1_rst_out_data", out_data, 0);
            check("t1_rst_busy", busy, 0);
        end
        #2 rst = 1'b0;
        @(negedge clk);
        check("t1_ready_after_release", in_ready, 1);
        repeat (10) begin
            @(negedge clk);
            check("t1_no_out_valid", out_valid, 0);
        end

        directed("t2", 8'h81, 3'd0, 8'h81, 1'b0);
        directed("t3", 8'hB5, 3'd3, ROT ? 8'hAD : 8'hA8, 1'b1);
        directed("t4", 8'h01, 3'd7, 8'h80, 1'b0);

        // Output stall in DONE with a competing offer.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        in_shamt  = 3'd2;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("t5_reached_done", out_valid, 1);
        check("t5_result", out_data, 8'hF0);
        held_d   = out_data;
        held_c   = out_carry;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_shamt = 3'd1;
        repeat (5) begin
            @(negedge clk);
            check("t5_hold_data", out_data, held_d);
            check("t5_hold_carry", out_carry, held_c);
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_back_to_idle", in_ready, 1);
        check("t5_valid_dropped", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_offer_accepted", busy, 1);
        @(negedge clk);
        check("t5_second_valid", out_valid, 1);
        check("t5_second_data", out_data, 8'hB4);
        check("t5_second_carry", out_carry, 0);
        @(negedge clk);

        // Random stream with random output stalls.
        acc_base = m_accepts;
        cmp_base = m_completed;
        rand_rdy = 1'b1;
        for (int k = 0; k < N_RAND; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_shamt = SW'($urandom_range(0, W - 1));
            start    = m_accepts;
            t        = 0;
            do begin
                tick();
                t++;
            end while (m_accepts == start && t < 200);
            check("rand_accept", m_accepts - start, 1);
        end
        in_valid = 1'b0;
        t = 0;
        while (m_completed - cmp_base < N_RAND && t < 2000) begin
            tick();
            t++;
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rand_accepted_count", m_accepts - acc_base, N_RAND);
        check("rand_completed_count", m_completed - cmp_base, N_RAND);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
